// File: rtl/simd_lane_accumulator_16bits.sv
// Per-lane accumulator behind the precision-configurable 8-bit multiplier.
// Unpacks the 16-bit packed product into 1/2/4 lanes, extends each lane and sums a group of beats.
module simd_lane_accumulator_16bits #(
  parameter  int ACC_LEN = 16,
  parameter  int GUARD   = 8,
  localparam int ACC_W   = 16 + GUARD,
  localparam int CNT_W   = $clog2(ACC_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        C,
  input  logic               A_sign,
  input  logic               B_sign,
  input  logic               HALF_0,
  input  logic               HALF_1,
  input  logic               HALF_2,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*ACC_W-1:0] acc_out,
  output logic [2:0]         out_mode,
  output logic [CNT_W-1:0]   out_count,
  output logic               overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0][ACC_W-1:0]   acc_q, acc_d;
  logic [2:0]              mode_q, mode_d;
  logic                    signed_q, signed_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;

  logic                    first_beat;
  logic                    accept;
  logic [2:0]              mode_in;
  logic [2:0]              mode_eff;
  logic                    sign_eff;
  logic [15:0]             lane_p  [4];
  logic [ACC_W-1:0]        lane_ext[4];
  logic [ACC_W:0]          lane_sum[4];
  logic [3:0]              lane_ovf;

  assign in_ready   = (state_q != HOLD);
  assign accept     = in_valid & in_ready;
  assign first_beat = (state_q == IDLE);

  // Mode bits after priority resolution: HALF_2 beats HALF_1 beats HALF_0; none set runs as 8x8.
  assign mode_in  = HALF_2 ? 3'b100 : (HALF_1 ? 3'b010 : {2'b00, HALF_0});
  assign mode_eff = first_beat ? mode_in : mode_q;
  assign sign_eff = first_beat ? (A_sign | B_sign) : signed_q;

  // Lane unpack, extension to ACC_W, and the per-lane add with its overflow flag.
  always_comb begin
    // NOTE: every combinationally written variable gets a default first so no latch is inferred.
    for (int k = 0; k < 4; k++) begin
      lane_p[k] = 16'h0000;
    end
    if (mode_eff[2]) begin
      for (int k = 0; k < 4; k++) begin
        lane_p[k] = {{12{sign_eff & C[4*k+3]}}, C[4*k +: 4]};
      end
    end else if (mode_eff[1]) begin
      for (int k = 0; k < 2; k++) begin
        lane_p[k] = {{8{sign_eff & C[8*k+7]}}, C[8*k +: 8]};
      end
    end else begin
      lane_p[0] = C;
    end

    for (int k = 0; k < 4; k++) begin
      lane_ext[k] = sign_eff ? ACC_W'($signed(lane_p[k])) : ACC_W'(lane_p[k]);
      lane_sum[k] = {1'b0, acc_q[k]} + {1'b0, lane_ext[k]};
      if (sign_eff) begin
        lane_ovf[k] = (acc_q[k][ACC_W-1] == lane_ext[k][ACC_W-1]) &&
                      (lane_sum[k][ACC_W-1] != acc_q[k][ACC_W-1]);
      end else begin
        lane_ovf[k] = lane_sum[k][ACC_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mode_d     = mode_q;
    signed_d   = signed_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          for (int k = 0; k < 4; k++) begin
            acc_d[k] = lane_ext[k];
          end
          mode_d     = mode_in;
          signed_d   = A_sign | B_sign;
          count_d    = CNT_W'(1);
          overflow_d = 1'b0;
          state_d    = (in_last || ACC_LEN == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          for (int k = 0; k < 4; k++) begin
            acc_d[k] = lane_sum[k][ACC_W-1:0];
          end
          count_d    = count_q + CNT_W'(1);
          overflow_d = overflow_q | (|lane_ovf);
          state_d    = (in_last || (int'(count_q) + 1 == ACC_LEN)) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: the lane accumulators are reset too, since acc_out must read zero after reset.
      state_q    <= IDLE;
      acc_q      <= '0;
      mode_q     <= 3'b000;
      signed_q   <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mode_q     <= mode_d;
      signed_q   <= signed_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign acc_out   = acc_q;
  assign out_mode  = mode_q;
  assign out_count = count_q;
  assign overflow  = overflow_q;

endmodule
